// File: rtl/float_pkg.sv
// float_pkg: shared float decode types, bias and field helpers for the half-float datapath
package float_pkg;
  typedef enum logic [1:0] {ZERO_SUB, NORMAL, INF, NAN} fclass_e;
  localparam int TU_SAT = 0;
  localparam int TU_NAN = 1;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int unsigned field(input int unsigned x, input int lsb, input int w);
    return (x >> lsb) & ((32'd1 << w) - 1);
  endfunction
endpackage

// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: AXI-Stream beat bundle with master/slave views
interface float_to_fixed_if #(parameter int DW = 16, parameter int UW = 2);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic tvalid;
  logic tready;
  modport master(output tdata, tuser, tvalid, input tready);
  modport slave(input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/fp_unpack.sv
// fp_unpack: combinational float decode into sign, mantissa, class and fixed-point shift
module fp_unpack import float_pkg::*; #(
  parameter int EXP = 5,
  parameter int FRA = 10,
  parameter int FRAC_BITS = 8
) (
  input  logic [EXP+FRA:0]   f_i,
  output logic               sign_o,
  output logic [FRA:0]       mant_o,
  output fclass_e            cls_o,
  output logic signed [31:0] sh_o
);
  logic [EXP-1:0] e, e_eff;
  logic [FRA-1:0] f;
  always_comb begin
    e = EXP'(field(32'(f_i), FRA, EXP));
    f = FRA'(field(32'(f_i), 0, FRA));
    sign_o = f_i[EXP+FRA];
    e_eff = (e == '0) ? EXP'(1) : e;
    mant_o = {e != '0, f};
    cls_o = (e == '0) ? ZERO_SUB : (&e) ? ((f == '0) ? INF : NAN) : NORMAL;
    sh_o = $signed(32'(e_eff)) - bias(EXP) - FRA + FRAC_BITS;
  end
endmodule

// File: rtl/float_to_fixed.sv
// float_to_fixed: two-stage AXI-Stream converter from float to saturating signed fixed-point
module float_to_fixed import float_pkg::*; #(
  parameter int EXP = 5,
  parameter int FRA = 10,
  parameter int WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input logic aclk,
  input logic aresetn,
  float_to_fixed_if.slave  s_axis,
  float_to_fixed_if.master m_axis
);
  localparam int MW = FRA + 1;
  localparam int MAGW = MW + WIDTH + 1;
  localparam logic [MAGW-1:0] LIM = MAGW'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic sign_d, sign_q;
  logic [FRA:0] mant_d, mant_q;
  fclass_e cls_d, cls_q;
  logic signed [31:0] sh_d, sh_q;
  logic rdy_q, v1_q, v2_q, rdy1, rdy2, sat;
  logic [WIDTH-1:0] data_d, data_q;
  logic [1:0] user_d, user_q;
  logic [31:0] n;
  logic [MW:0] ext;
  logic [MAGW-1:0] mag;
  fp_unpack #(.EXP(EXP), .FRA(FRA), .FRAC_BITS(FRAC_BITS)) u_unpack (
    .f_i(s_axis.tdata), .sign_o(sign_d), .mant_o(mant_d), .cls_o(cls_d), .sh_o(sh_d)
  );
  assign rdy2 = !v2_q || m_axis.tready;
  assign rdy1 = !v1_q || rdy2;
  assign s_axis.tready = rdy_q && rdy1;
  assign m_axis.tvalid = v2_q;
  assign m_axis.tdata = data_q;
  assign m_axis.tuser = user_q;
  // ext keeps one guard bit below the kept magnitude for round-half-away
  always_comb begin
    n = 32'(-sh_q);
    ext = {mant_q, 1'b0} >> n;
    mag = !sh_q[31] ? MAGW'(mant_q) << sh_q
        : (n > 32'(MW + 1)) ? '0 : MAGW'(ext[MW:1]) + MAGW'(ext[0]);
    sat = (!sh_q[31] && sh_q > WIDTH && mant_q != '0) || (sign_q ? mag > LIM : mag >= LIM);
    user_d = '0;
    user_d[TU_NAN] = cls_q == NAN;
    user_d[TU_SAT] = cls_q == INF || (cls_q != NAN && sat);
    data_d = (cls_q == NAN) ? '0
           : user_d[TU_SAT] ? (sign_q ? NEG_MIN : POS_MAX)
           : sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sign_q <= 1'b0;
      mant_q <= '0;
      cls_q <= ZERO_SUB;
      sh_q <= '0;
      data_q <= '0;
      user_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (rdy1) v1_q <= s_axis.tvalid && s_axis.tready;
      if (s_axis.tvalid && s_axis.tready) begin
        sign_q <= sign_d;
        mant_q <= mant_d;
        cls_q <= cls_d;
        sh_q <= sh_d;
      end
      if (rdy2) v2_q <= v1_q;
      if (rdy2 && v1_q) begin
        data_q <= data_d;
        user_q <= user_d;
      end
    end
  end
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed and random checks of the float to Q7.8 converter against a real-arithmetic model
module tb_float_to_fixed;
  logic aclk, aresetn;
  float_to_fixed_if #(.DW(16), .UW(2)) s_if ();
  float_to_fixed_if #(.DW(16), .UW(2)) m_if ();
  float_to_fixed dut (.aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if));

  int n_vec = 0, n_err = 0, n_out = 0;
  logic [17:0] exp_q[$];
  logic [15:0] din [11] = '{16'h41B3, 16'hC1B3, 16'h5300, 16'h4F00, 16'hD800, 16'h5A40,
                            16'h7C00, 16'hFC00, 16'h7E00, 16'h00F3, 16'h8000};
  logic [17:0] dexp [11] = '{18'h002DA, 18'h0FD26, 18'h03800, 18'h01C00, 18'h08000, 18'h17FFF,
                             18'h17FFF, 18'h18000, 18'h20000, 18'h00000, 18'h00000};
  logic [15:0] bp [5];

  initial aclk = 0;
  always #5 aclk = ~aclk;

  // value = (-1)^s * mant * 2^(e_eff-25), scaled by 2^8, rounded half away from zero
  function automatic logic [17:0] model(input logic [15:0] x);
    int e = int'(x[14:10]);
    int fr = int'(x[9:0]);
    int k;
    int m;
    real a;
    if (e == 31) return (fr != 0) ? 18'h20000 : (x[15] ? 18'h18000 : 18'h17FFF);
    a = (e == 0) ? real'(fr) : real'(fr + 1024);
    k = ((e == 0) ? 1 : e) - 25 + 8;
    for (int i = 0; i < k; i++) a = a * 2.0;
    for (int i = 0; i < -k; i++) a = a / 2.0;
    m = $rtoi($floor(a + 0.5));
    if (!x[15] && m > 32767) return 18'h17FFF;
    if (x[15] && m > 32768) return 18'h18000;
    return {2'b00, x[15] ? 16'(-m) : 16'(m)};
  endfunction

  function automatic logic [15:0] rnd();
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    return {1'($urandom), 5'($urandom_range(5, 22)), 10'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(output bit sf);
    bit mf;
    #1;
    sf = s_if.tvalid && s_if.tready;
    mf = m_if.tvalid && m_if.tready;
    if (m_if.tvalid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL spurious_out: observed %h expected no beat", {m_if.tuser, m_if.tdata});
      end else chk("scoreboard", 32'({m_if.tuser, m_if.tdata}), 32'(exp_q[0]));
    end
    if (mf && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (sf) exp_q.push_back(model(s_if.tdata));
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    bit f;
    int sent;
    aresetn = 0;
    s_if.tvalid = 0;
    s_if.tdata = '0;
    s_if.tuser = '0;
    m_if.tready = 1;
    repeat (3) tick(f);
    chk("rst_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_tdata", 32'(m_if.tdata), 0);
    chk("rst_tuser", 32'(m_if.tuser), 0);
    aresetn = 1;
    tick(f);
    chk("rst_tready", 32'(s_if.tready), 1);

    for (int i = 0; i < 11; i++) begin
      s_if.tdata = din[i];
      s_if.tvalid = 1;
      f = 0;
      for (int k = 0; k < 10 && !f; k++) tick(f);
      chk($sformatf("accept%0d", i), 32'(f), 1);
      s_if.tvalid = 0;
      chk($sformatf("lat0_%0d", i), 32'(m_if.tvalid), 0);
      tick(f);
      chk($sformatf("lat1_%0d", i), 32'(m_if.tvalid), 1);
      chk($sformatf("dir_%h", din[i]), 32'({m_if.tuser, m_if.tdata}), 32'(dexp[i]));
      tick(f);
    end

    for (int i = 0; i < 5; i++) bp[i] = rnd();
    sent = 0;
    n_out = 0;
    s_if.tdata = bp[0];
    s_if.tvalid = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      m_if.tready = !(cyc >= 2 && cyc <= 4);
      if (cyc == 3) begin
        #1;
        chk("bp_tready_low", 32'(s_if.tready), 0);
      end
      tick(f);
      if (f) begin
        sent++;
        if (sent < 5) s_if.tdata = bp[sent];
        else s_if.tvalid = 0;
      end
    end
    chk("bp_sent", 32'(sent), 5);
    chk("bp_outputs", 32'(n_out), 5);

    for (int cyc = 0; cyc < 400; cyc++) begin
      m_if.tready = $urandom_range(0, 3) != 0;
      tick(f);
      if (!s_if.tvalid || f) begin
        s_if.tvalid = $urandom_range(0, 3) != 0;
        s_if.tdata = rnd();
      end
    end
    s_if.tvalid = 0;
    m_if.tready = 1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick(f);
    chk("rand_drained", 32'(exp_q.size()), 0);

    m_if.tready = 0;
    s_if.tvalid = 1;
    s_if.tdata = 16'h41B3;
    tick(f);
    s_if.tdata = 16'h5300;
    tick(f);
    s_if.tvalid = 0;
    chk("inflight_valid", 32'(m_if.tvalid), 1);
    aresetn = 0;
    #1;
    chk("midrst_tvalid", 32'(m_if.tvalid), 0);
    exp_q.delete();
    @(negedge aclk);
    tick(f);
    aresetn = 1;
    m_if.tready = 1;
    tick(f);
    chk("post_rst_tready", 32'(s_if.tready), 1);
    chk("no_stale", 32'(m_if.tvalid), 0);
    tick(f);
    chk("no_stale2", 32'(m_if.tvalid), 0);
    s_if.tvalid = 1;
    s_if.tdata = 16'h4F00;
    tick(f);
    chk("post_rst_accept", 32'(f), 1);
    s_if.tvalid = 0;
    chk("post_rst_lat0", 32'(m_if.tvalid), 0);
    tick(f);
    chk("post_rst_lat1", 32'(m_if.tvalid), 1);
    chk("post_rst_data", 32'({m_if.tuser, m_if.tdata}), 32'h01C00);
    tick(f);
    chk("final_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
